// File: rtl/ysyx_22040365_ifu_pkg.sv
// Shared types and constants for the ysyx_22040365 instruction fetch unit.
// Holds the FSM encoding and the FIFO entry layout.
package ysyx_22040365_ifu_pkg;

    localparam int XLEN   = 64;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } ifu_state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   pc;
    } ifu_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_22040365_ifu_fifo.sv
// Small synchronous FIFO of fetched {inst, pc} entries.
// The head entry comes straight from registers; flush empties it in one cycle.
module ysyx_22040365_ifu_fifo
    import ysyx_22040365_ifu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  ifu_entry_t                 din,
    input  logic                       pop,
    input  logic                       flush,
    output ifu_entry_t                 dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    ifu_entry_t     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_22040365_ifu.sv
// Instruction fetch unit: one-outstanding word reads into a small FIFO,
// with redirect flushing and draining of stale responses.
module ysyx_22040365_ifu
    import ysyx_22040365_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = RESET_PC_DEF,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [63:0] req_addr,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        halt
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    ifu_state_t     state;
    ifu_state_t     state_n;
    logic [63:0]    fetch_pc;
    logic [63:0]    fetch_pc_n;
    logic [63:0]    req_pc;
    logic [63:0]    req_pc_n;

    logic           hs;
    logic           pop;
    logic           push;
    logic           room;
    logic           room_push;
    logic [CW-1:0]  count;
    logic [CW-1:0]  cnt_left;
    logic           full;
    logic           empty;
    ifu_entry_t     head;
    ifu_entry_t     entry;

    assign req_valid  = (state == S_REQ);
    assign req_addr   = fetch_pc;
    assign hs         = req_valid && req_ready;
    assign inst_valid = !empty;
    assign pop        = inst_valid && inst_ready;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

    // Occupancy once this cycle's pop has happened; a redirect empties the FIFO.
    assign cnt_left  = count - CW'(pop);
    assign room      = redirect_valid || !full || pop;
    assign room_push = (cnt_left + 1'b1) < CW'(BUF_DEPTH);

    assign entry.inst = rsp_data;
    assign entry.pc   = req_pc;

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        req_pc_n   = req_pc;
        push       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!redirect_valid && !halt && room) begin
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                if (hs) begin
                    req_pc_n   = fetch_pc;
                    fetch_pc_n = fetch_pc + 64'd4;
                    state_n    = redirect_valid ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (rsp_valid) begin
                    push    = !redirect_valid;
                    state_n = (!halt && (redirect_valid || room_push))
                              ? S_REQ : S_IDLE;
                end else if (redirect_valid) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (rsp_valid) begin
                    state_n = (!halt && room) ? S_REQ : S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (redirect_valid) begin
            fetch_pc_n = align_pc(redirect_pc);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            req_pc   <= req_pc_n;
        end
    end

    ysyx_22040365_ifu_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (entry),
        .pop   (pop),
        .flush (redirect_valid),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_ysyx_22040365_ifu.sv
// Bench for ysyx_22040365_ifu: directed scenarios plus random traffic
// checked every cycle against a queue-based fetch model.
module tb_ysyx_22040365_ifu;

    localparam logic [63:0] RPC   = 64'h0000_0000_8000_0000;
    localparam logic [63:0] WPC   = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid, req_ready, rsp_valid, inst_valid, inst_ready;
    logic        redirect_valid, halt;
    logic [63:0] req_addr, inst_pc, redirect_pc;
    logic [31:0] rsp_data, inst;

    logic        b_req_valid, b_req_ready, b_rsp_valid, b_inst_valid, b_inst_ready;
    logic [63:0] b_req_addr, b_inst_pc;
    logic [31:0] b_rsp_data, b_inst;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: fetch pointer, request flag, outstanding kind, queue.
    logic [63:0] m_pc;
    logic [63:0] m_rpc;
    bit          m_pend;
    int          m_out;
    logic [31:0] qi[$];
    logic [63:0] qp[$];

    always #5 clk = ~clk;

    ysyx_22040365_ifu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt)
    );

    ysyx_22040365_ifu #(.RESET_PC(WPC), .BUF_DEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
        .inst_valid(b_inst_valid), .inst_ready(b_inst_ready),
        .inst(b_inst), .inst_pc(b_inst_pc),
        .redirect_valid(1'b0), .redirect_pc(64'd0),
        .halt(1'b0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = RPC;
        m_rpc  = RPC;
        m_pend = 0;
        m_out  = 0;
        qi.delete();
        qp.delete();
    endtask

    task automatic step(input bit rr, input bit rv, input logic [31:0] rd,
                        input bit rdv, input logic [63:0] rpc,
                        input bit hl, input bit ir);
        int n_left;
        bit pop;
        req_ready      = rr;
        rsp_valid      = rv;
        rsp_data       = rd;
        redirect_valid = rdv;
        redirect_pc    = rpc;
        halt           = hl;
        inst_ready     = ir;
        #1;
        chk("req_valid", 64'(req_valid), 64'(m_pend));
        chk("req_addr", req_addr, m_pc);
        chk("inst_valid", 64'(inst_valid), 64'(qi.size() > 0));
        if (qi.size() > 0) begin
            chk("inst", 64'(inst), 64'(qi[0]));
            chk("inst_pc", inst_pc, qp[0]);
        end
        pop = (qi.size() > 0) && ir;
        if (pop) begin
            void'(qi.pop_front());
            void'(qp.pop_front());
        end
        n_left = qi.size();
        if (rdv) begin
            qi.delete();
            qp.delete();
        end
        if (m_pend) begin
            if (rr) begin
                m_rpc  = m_pc;
                m_pc   = m_pc + 64'd4;
                m_pend = 0;
                m_out  = rdv ? 2 : 1;
            end
        end else if (m_out == 1) begin
            if (rv) begin
                if (!rdv) begin
                    qi.push_back(rd);
                    qp.push_back(m_rpc);
                end
                m_out  = 0;
                m_pend = !hl && (rdv || n_left + 1 < DEPTH);
            end else if (rdv) begin
                m_out = 2;
            end
        end else if (m_out == 2) begin
            if (rv) begin
                m_out  = 0;
                m_pend = !hl && (rdv || n_left < DEPTH);
            end
        end else if (!rdv && !hl && n_left < DEPTH) begin
            m_pend = 1;
        end
        if (rdv) m_pc = {rpc[63:2], 2'b00};
        @(negedge clk);
    endtask

    initial begin
        req_ready = 0; rsp_valid = 0; rsp_data = 0; inst_ready = 0;
        redirect_valid = 0; redirect_pc = 0; halt = 1;
        b_req_ready = 1; b_rsp_valid = 0; b_rsp_data = 0; b_inst_ready = 1;
        #12;
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_req_addr", req_addr, RPC);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_inst_pc", inst_pc, 64'd0);
        chk("rst_wrap_addr", b_req_addr, WPC);

        // Wrap-around fetch on the second instance; main instance halted.
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("wrap_req_valid0", 64'(b_req_valid), 64'd1);
        chk("wrap_addr0", b_req_addr, WPC);
        @(negedge clk);
        b_rsp_valid = 1; b_rsp_data = 32'hA1;
        @(negedge clk);
        b_rsp_valid = 0;
        chk("wrap_inst0", 64'(b_inst), 64'hA1);
        chk("wrap_pc0", b_inst_pc, WPC);
        chk("wrap_addr1", b_req_addr, 64'd0);
        @(negedge clk);
        b_rsp_valid = 1; b_rsp_data = 32'hA2;
        @(negedge clk);
        b_rsp_valid = 0;
        chk("wrap_inst1", 64'(b_inst), 64'hA2);
        chk("wrap_pc1", b_inst_pc, 64'd0);
        b_req_ready = 0;

        rst = 1;
        @(negedge clk);
        rst = 0;
        halt = 0;
        model_reset();

        // First fetch and registered delivery.
        step(1, 0, 0, 0, 0, 0, 0);
        chk("t1_addr", req_addr, RPC);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h13, 0, 0, 0, 0);
        chk("t1_inst", 64'(inst), 64'h13);
        chk("t1_pc", inst_pc, RPC);
        step(0, 0, 0, 0, 0, 0, 1);

        // Fill the FIFO while decode stalls.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h11, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h22, 0, 0, 0, 0);
        chk("full_req_valid", 64'(req_valid), 64'd0);
        chk("full_addr", req_addr, 64'h8000_000C);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("pop_req_valid", 64'(req_valid), 64'd1);
        chk("pop_addr", req_addr, 64'h8000_000C);
        chk("pop_inst", 64'(inst), 64'h22);

        // Redirect while waiting: stale response is drained.
        step(1, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 64'h8000_0100, 0, 0);
        step(0, 1, 32'hDEADBEEF, 0, 0, 0, 0);
        chk("drain_inst_valid", 64'(inst_valid), 64'd0);
        chk("drain_addr", req_addr, 64'h8000_0100);
        step(1, 0, 0, 0, 0, 0, 0);

        // Redirect coincident with the response.
        step(0, 1, 32'h55, 1, 64'h8000_0203, 0, 0);
        chk("rr_inst_valid", 64'(inst_valid), 64'd0);
        chk("rr_addr", req_addr, 64'h8000_0200);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h77, 0, 0, 0, 0);

        // Asynchronous reset between edges.
        chk("pre_rst_req_valid", 64'(req_valid), 64'd1);
        chk("pre_rst_inst_valid", 64'(inst_valid), 64'd1);
        #2 rst = 1;
        #1;
        chk("arst_req_valid", 64'(req_valid), 64'd0);
        chk("arst_inst_valid", 64'(inst_valid), 64'd0);
        chk("arst_addr", req_addr, RPC);
        @(negedge clk);
        rsp_valid = 1;
        rsp_data  = 32'h99;
        @(negedge clk);
        rsp_valid = 0;
        rst = 0;
        model_reset();
        step(0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_addr", req_addr, RPC);
        chk("post_rst_req_valid", 64'(req_valid), 64'd1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit          rr, rv, rdv, hl, ir;
            logic [31:0] rd;
            logic [63:0] rpc;
            rr  = ($urandom % 2) == 0;
            rv  = (m_out != 0) ? (($urandom % 3) == 0) : (($urandom % 8) == 0);
            rd  = $urandom;
            rdv = ($urandom % 16) == 0;
            rpc = {$urandom, $urandom};
            hl  = ($urandom % 8) == 0;
            ir  = ($urandom % 2) == 0;
            step(rr, rv, rd, rdv, rpc, hl, ir);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
